// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode map and pipeline entry structs.
// No logic; constants and typedefs only.
// Used by the alu, the arbiter interface and the arbiter top.
package alu_pkg;

    localparam int OP_W   = 6;
    localparam int DATA_W = 32;
    localparam int SH_W   = $clog2(DATA_W);

    localparam logic [OP_W-1:0] ALU_ADD = 6'd1;
    localparam logic [OP_W-1:0] ALU_SUB = 6'd2;
    localparam logic [OP_W-1:0] ALU_AND = 6'd3;
    localparam logic [OP_W-1:0] ALU_OR  = 6'd4;
    localparam logic [OP_W-1:0] ALU_NOT = 6'd5;
    localparam logic [OP_W-1:0] ALU_XOR = 6'd6;
    localparam logic [OP_W-1:0] ALU_SLL = 6'd7;
    localparam logic [OP_W-1:0] ALU_SRL = 6'd8;
    localparam logic [OP_W-1:0] ALU_SLT = 6'd9;
    localparam logic [OP_W-1:0] ALU_SEQ = 6'd10;
    localparam logic [OP_W-1:0] ALU_MUL = 6'd11;
    localparam logic [OP_W-1:0] ALU_OP_MAX = 6'd11;

    // One accepted request waiting in the issue stage
    typedef struct packed {
        logic              id;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } iss_entry_t;

    // One computed result waiting for the consumer
    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] out1;
        logic [DATA_W-1:0] out2;
        logic              zero;
        logic              err;
    } rsp_entry_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and writeback.
// No logic; wires only.
// req_* uses per-requester valid/ready, rsp_* a single valid/ready pair.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [OP_W-1:0]   req_op0;
    logic [OP_W-1:0]   req_op1;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_b1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_out1;
    logic [DATA_W-1:0] rsp_out2;
    logic              rsp_zero;
    logic              rsp_err;

    // Requesters plus result consumer
    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_zero, rsp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Combinational MIPS ALU: add/sub/logic/shift/slt/seq and 32x32 unsigned multiply.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller registers inputs and outputs.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_out1,
    output logic [DATA_W-1:0] o_out2,
    output logic              o_zero,
    output logic              o_err
);

    logic [2*DATA_W-1:0] w_prod;

    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

    // Opcode decode; anything outside the map yields zero results with err set
    always_comb begin
        o_out1 = '0;
        o_out2 = '0;
        o_err  = 1'b0;
        case (i_op)
            ALU_ADD: o_out1 = i_a + i_b;
            ALU_SUB: o_out1 = i_a - i_b;
            ALU_AND: o_out1 = i_a & i_b;
            ALU_OR:  o_out1 = i_a | i_b;
            ALU_NOT: o_out1 = ~i_a;
            ALU_XOR: o_out1 = i_a ^ i_b;
            ALU_SLL: o_out1 = i_a << i_b[SH_W-1:0];
            ALU_SRL: o_out1 = i_a >> i_b[SH_W-1:0];
            ALU_SLT: o_out1 = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SEQ: o_out1 = {{(DATA_W-1){1'b0}}, (i_a == i_b)};
            ALU_MUL: begin
                o_out1 = w_prod[2*DATA_W-1:DATA_W];
                o_out2 = w_prod[DATA_W-1:0];
            end
            default: o_err = 1'b1;
        endcase
    end

    assign o_zero = (o_out1 == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters, with issue and result registers.
// Latency: transfer in cycle N gives rsp_valid in cycle N+2; one op per cycle sustained.
// Backpressure: both stages hold when rsp_valid & !rsp_ready; req_ready drops combinationally.
// Optional ALU_ARB_PERF_EN adds saturating grant/stall counters.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
`ifdef ALU_ARB_PERF_EN
    output logic [15:0] perf_grant0,
    output logic [15:0] perf_grant1,
    output logic [15:0] perf_stall,
`endif
    alu_arbiter_if.slave bus
);

    logic       r_started;
    logic       r_prio;
    logic       r_iss_vld;
    iss_entry_t r_iss;
    logic       r_rsp_vld;
    rsp_entry_t r_rsp;

    logic              w_adv;
    logic              w_gnt_id;
    logic [1:0]        w_ready;
    logic              w_xfer;
    iss_entry_t        w_sel;
    logic [DATA_W-1:0] w_out1;
    logic [DATA_W-1:0] w_out2;
    logic              w_zero;
    logic              w_err;

    // Issue stage moves only when the result register is empty or draining
    assign w_adv = !r_rsp_vld | bus.rsp_ready;

    // Prefer the pointer; fall back to the other requester if only it is valid
    always_comb begin
        w_gnt_id = r_prio;
        if (!bus.req_valid[r_prio] && bus.req_valid[~r_prio])
            w_gnt_id = ~r_prio;
    end

    assign w_ready = {w_gnt_id, ~w_gnt_id} & {2{w_adv & r_started}};
    assign w_xfer  = |(bus.req_valid & w_ready);

    // Operand mux for the granted requester
    always_comb begin
        w_sel.id = w_gnt_id;
        w_sel.op = w_gnt_id ? bus.req_op1 : bus.req_op0;
        w_sel.a  = w_gnt_id ? bus.req_a1  : bus.req_a0;
        w_sel.b  = w_gnt_id ? bus.req_b1  : bus.req_b0;
    end

    alu u_alu (
        .i_op   (r_iss.op),
        .i_a    (r_iss.a),
        .i_b    (r_iss.b),
        .o_out1 (w_out1),
        .o_out2 (w_out2),
        .o_zero (w_zero),
        .o_err  (w_err)
    );

    // Start-up gate, round-robin pointer and both pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_prio    <= 1'b0;
            r_iss_vld <= 1'b0;
            r_iss     <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp     <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_xfer)
                r_prio <= ~w_gnt_id;
            if (w_adv) begin
                r_iss_vld <= w_xfer;
                if (w_xfer)
                    r_iss <= w_sel;
                r_rsp_vld <= r_iss_vld;
                if (r_iss_vld) begin
                    r_rsp.id   <= r_iss.id;
                    r_rsp.out1 <= w_out1;
                    r_rsp.out2 <= w_out2;
                    r_rsp.zero <= w_zero;
                    r_rsp.err  <= w_err;
                end
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_id    = r_rsp.id;
    assign bus.rsp_out1  = r_rsp.out1;
    assign bus.rsp_out2  = r_rsp.out2;
    assign bus.rsp_zero  = r_rsp.zero;
    assign bus.rsp_err   = r_rsp.err;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_pg0;
    logic [15:0] r_pg1;
    logic [15:0] r_pstall;

    // Saturating event counters for grants per requester and result stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pg0    <= '0;
            r_pg1    <= '0;
            r_pstall <= '0;
        end else begin
            if (w_xfer && !w_gnt_id && r_pg0 != 16'hFFFF)
                r_pg0 <= r_pg0 + 16'd1;
            if (w_xfer && w_gnt_id && r_pg1 != 16'hFFFF)
                r_pg1 <= r_pg1 + 16'd1;
            if (r_rsp_vld && !bus.rsp_ready && r_pstall != 16'hFFFF)
                r_pstall <= r_pstall + 16'd1;
        end
    end

    assign perf_grant0 = r_pg0;
    assign perf_grant1 = r_pg1;
    assign perf_stall  = r_pstall;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed opcode/latency cases, arbitration,
// backpressure and reset, then a random mixed phase.
// Results are predicted at request acceptance and compared when consumed.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    int n_xfer = 0;
    int n_gnt [2];
    logic [1:0] acc = 2'b00;
    bit m_prio = 1'b0;
    rsp_entry_t q[$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic rsp_entry_t model(input bit id, input logic [5:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
        rsp_entry_t r;
        logic [63:0] p;
        r.id = id; r.out1 = 32'h0; r.out2 = 32'h0; r.err = 1'b0;
        case (int'(op))
            1:  r.out1 = a + b;
            2:  r.out1 = a - b;
            3:  r.out1 = a & b;
            4:  r.out1 = a | b;
            5:  r.out1 = ~a;
            6:  r.out1 = a ^ b;
            7:  r.out1 = a << b[4:0];
            8:  r.out1 = a >> b[4:0];
            9:  r.out1 = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            10: r.out1 = (a == b) ? 32'd1 : 32'd0;
            11: begin
                p = 64'(a) * 64'(b);
                r.out1 = p[63:32];
                r.out2 = p[31:0];
            end
            default: r.err = 1'b1;
        endcase
        r.zero = (r.out1 == 32'h0);
        return r;
    endfunction

    // Monitor: arbitration model, scoreboard push/pop, stall stability
    initial begin
        rsp_entry_t cur, held, e;
        bit hold_vld;
        logic [1:0] xf;
        bit gid, exp_g;
        hold_vld = 1'b0;
        held = '0;
        n_gnt[0] = 0; n_gnt[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_prio = 1'b0;
                hold_vld = 1'b0;
                acc = 2'b00;
            end else begin
                xf = bus.req_valid & bus.req_ready;
                acc = xf;
                cur = '{bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_zero, bus.rsp_err};
                if (xf != 2'b00) begin
                    check_eq("ready_onehot", 128'($countones(bus.req_ready)), 128'd1);
                    gid = xf[1];
                    exp_g = bus.req_valid[m_prio] ? m_prio :
                            (bus.req_valid[!m_prio] ? !m_prio : m_prio);
                    check_eq("grant_id", 128'(gid), 128'(exp_g));
                    if (gid) q.push_back(model(1'b1, bus.req_op1, bus.req_a1, bus.req_b1));
                    else     q.push_back(model(1'b0, bus.req_op0, bus.req_a0, bus.req_b0));
                    m_prio = !gid;
                    n_xfer++;
                    n_gnt[gid]++;
                end
                if (hold_vld) begin
                    check_eq("stall_valid", 128'(bus.rsp_valid), 128'd1);
                    check_eq("stall_data", 128'(cur), 128'(held));
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (q.size() == 0) begin
                        check_eq("rsp_unexpected", 128'd1, 128'd0);
                    end else begin
                        e = q.pop_front();
                        check_eq("rsp_id",   128'(cur.id),   128'(e.id));
                        check_eq("rsp_out1", 128'(cur.out1), 128'(e.out1));
                        check_eq("rsp_out2", 128'(cur.out2), 128'(e.out2));
                        check_eq("rsp_zero", 128'(cur.zero), 128'(e.zero));
                        check_eq("rsp_err",  128'(cur.err),  128'(e.err));
                    end
                end
                hold_vld = bus.rsp_valid & !bus.rsp_ready;
                held = cur;
            end
        end
    end

    function automatic logic [5:0] rnd_op();
        int r;
        r = $urandom_range(0, 14);
        return (r <= 12) ? 6'(r) : 6'd63;
    endfunction

    task automatic set_req(input bit id, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
        else    begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic set_rnd(input bit id);
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_req(id, rnd_op(), a, b);
    endtask

    task automatic all_outputs_zero(input string tag);
        check_eq({tag, "_req_ready"}, 128'(bus.req_ready), 128'd0);
        check_eq({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'd0);
        check_eq({tag, "_rsp_id"},    128'(bus.rsp_id),    128'd0);
        check_eq({tag, "_rsp_out1"},  128'(bus.rsp_out1),  128'd0);
        check_eq({tag, "_rsp_out2"},  128'(bus.rsp_out2),  128'd0);
        check_eq({tag, "_rsp_zero"},  128'(bus.rsp_zero),  128'd0);
        check_eq({tag, "_rsp_err"},   128'(bus.rsp_err),   128'd0);
    endtask

    // Random driver: requests held until accepted; stops early once target transfers reached
    task automatic rand_phase(input int max_cyc, input int target, input int vpct, input int rpct);
        int x0;
        x0 = n_xfer;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            if (target > 0 && n_xfer - x0 >= target) break;
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i] || acc[i]) begin
                    if ($urandom_range(1, 100) <= vpct) set_rnd(1'(i));
                    else bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(1, 100) <= rpct);
        end
        bus.req_valid = 2'b00;
        if (target > 0) check_eq("xfer_budget", 128'(n_xfer - x0), 128'(target));
    endtask

    task automatic drain();
        int n;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (n < 40 && (q.size() != 0 || bus.rsp_valid)) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_empty", 128'(q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    // Single request, then exact N+2 latency and result values
    task automatic issue_expect(input string tag, input bit id, input logic [5:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic ez, input logic ee);
        int n;
        set_req(id, op, a, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!acc[id] && n < 50);
        check_eq({tag, "_accept"}, 128'(acc[id]), 128'd1);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        @(negedge clk);
        check_eq({tag, "_lat_n1"}, 128'(bus.rsp_valid), 128'd0);
        @(negedge clk);
        check_eq({tag, "_lat_n2"}, 128'(bus.rsp_valid), 128'd1);
        check_eq({tag, "_id"},     128'(bus.rsp_id),    128'(id));
        check_eq({tag, "_out1"},   128'(bus.rsp_out1),  128'(e1));
        check_eq({tag, "_out2"},   128'(bus.rsp_out2),  128'(e2));
        check_eq({tag, "_zero"},   128'(bus.rsp_zero),  128'(ez));
        check_eq({tag, "_err"},    128'(bus.rsp_err),   128'(ee));
        @(posedge clk); #1;
    endtask

    initial begin
        int x0;
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_op0 = '0; bus.req_op1 = '0;
        bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
        bus.rsp_ready = 1'b1;
        #3;
        all_outputs_zero("reset");
        set_rnd(1'b0);
        set_rnd(1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_cycle_ready", 128'(bus.req_ready), 128'd0);

        // Both valid every cycle: strict alternation, 50/50 over 100 ops
        n_gnt[0] = 0; n_gnt[1] = 0;
        rand_phase(300, 100, 100, 100);
        check_eq("fair_gnt0", 128'(n_gnt[0]), 128'd50);
        check_eq("fair_gnt1", 128'(n_gnt[1]), 128'd50);
        drain();

        issue_expect("add",   1'b0, 6'd1,  32'd5,        32'd7, 32'd12, 32'h0,         1'b0, 1'b0);
        issue_expect("mul",   1'b1, 6'd11, 32'hFFFFFFFF, 32'd2, 32'd1,  32'hFFFFFFFE,  1'b0, 1'b0);
        issue_expect("slt",   1'b0, 6'd9,  32'hFFFFFFFF, 32'd0, 32'd1,  32'h0,         1'b0, 1'b0);
        issue_expect("op0",   1'b0, 6'd0,  32'd9,        32'd3, 32'd0,  32'h0,         1'b1, 1'b1);
        issue_expect("op63",  1'b1, 6'd63, 32'd9,        32'd3, 32'd0,  32'h0,         1'b1, 1'b1);
        issue_expect("sub_z", 1'b1, 6'd2,  32'd44,       32'd44, 32'd0, 32'h0,         1'b1, 1'b0);
        drain();

        // Stall: five cycles with rsp_ready low admit exactly two ops
        x0 = n_xfer;
        rand_phase(5, 0, 100, 0);
        check_eq("stall_accepts", 128'(n_xfer - x0), 128'd2);
        check_eq("stall_rdy_low", 128'(bus.req_ready), 128'd0);
        drain();

        // Reset with both stages full, then first grant to requester 0
        rand_phase(3, 0, 100, 0);
        set_rnd(1'b0);
        set_rnd(1'b1);
        @(negedge clk);
        check_eq("pre_rst_full", 128'(bus.rsp_valid), 128'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        all_outputs_zero("midrst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_cycle1", 128'(bus.req_ready), 128'd0);
        @(negedge clk);
        check_eq("post_rst_grant0", 128'(bus.req_ready), 128'd1);
        @(posedge clk); #1;
        drain();

        rand_phase(400, 0, 60, 70);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
